// File: rtl/rect_fill_engine_if.sv
// Command and pixel-write bundle between a fill requester and rect_fill_engine.
// master issues commands and observes the pixel stream; slave is the engine.
interface rect_fill_engine_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [9:0] CMD_X0;
  logic [9:0] CMD_Y0;
  logic [9:0] CMD_W;
  logic [9:0] CMD_H;
  logic [7:0] CMD_COLOR;
  logic       PIX_WE;
  logic [9:0] PIX_HORIZONTAL;
  logic [9:0] PIX_VERTICAL;
  logic [7:0] PIX_COLOR;
  logic       BUSY;
  logic       DONE;

  modport master (
    output CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR,
    input  CMD_READY, PIX_WE, PIX_HORIZONTAL, PIX_VERTICAL, PIX_COLOR, BUSY, DONE
  );

  modport slave (
    input  CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOR,
    output CMD_READY, PIX_WE, PIX_HORIZONTAL, PIX_VERTICAL, PIX_COLOR, BUSY, DONE
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts one fill command, sweeps the clipped rectangle
// in raster order at one pixel per clock, then pulses DONE.
module rect_fill_engine #(
  parameter int unsigned HSIZE = 800,
  parameter int unsigned VSIZE = 600
) (
  input  logic PIXEL_CLK,
  input  logic RST_N,
  rect_fill_engine_if.slave bus
);
  localparam logic [10:0] HSIZE_EXT = 11'(HSIZE);
  localparam logic [10:0] VSIZE_EXT = 11'(VSIZE);

  typedef enum logic [1:0] {IDLE, FILL, FIN} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  x0_reg, x0_next;
  logic [10:0] xe_reg, xe_next;
  logic [10:0] ye_reg, ye_next;
  logic [9:0]  pix_h_reg, pix_h_next;
  logic [9:0]  pix_v_reg, pix_v_next;
  logic [7:0]  pix_c_reg, pix_c_next;
  logic        pix_we_reg, pix_we_next;
  logic        done_reg, done_next;

  logic [10:0] x_sum, y_sum, x_clip, y_clip, x_inc, y_inc;
  logic        cmd_empty, row_end, last_pixel;

  // The registered pixel outputs double as the sweep cursor.
  always_ff @(posedge PIXEL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      x0_reg     <= '0;
      xe_reg     <= '0;
      ye_reg     <= '0;
      pix_h_reg  <= '0;
      pix_v_reg  <= '0;
      pix_c_reg  <= '0;
      pix_we_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x0_reg     <= x0_next;
      xe_reg     <= xe_next;
      ye_reg     <= ye_next;
      pix_h_reg  <= pix_h_next;
      pix_v_reg  <= pix_v_next;
      pix_c_reg  <= pix_c_next;
      pix_we_reg <= pix_we_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x0_next     = x0_reg;
    xe_next     = xe_reg;
    ye_next     = ye_reg;
    pix_h_next  = pix_h_reg;
    pix_v_next  = pix_v_reg;
    pix_c_next  = pix_c_reg;
    pix_we_next = 1'b0;
    done_next   = 1'b0;

    // Exclusive end coordinates, clipped to the visible area in 11 bits.
    x_sum  = {1'b0, bus.CMD_X0} + {1'b0, bus.CMD_W};
    y_sum  = {1'b0, bus.CMD_Y0} + {1'b0, bus.CMD_H};
    x_clip = (x_sum > HSIZE_EXT) ? HSIZE_EXT : x_sum;
    y_clip = (y_sum > VSIZE_EXT) ? VSIZE_EXT : y_sum;
    cmd_empty = (bus.CMD_W == '0) || (bus.CMD_H == '0) ||
                ({1'b0, bus.CMD_X0} >= HSIZE_EXT) || ({1'b0, bus.CMD_Y0} >= VSIZE_EXT);

    x_inc      = {1'b0, pix_h_reg} + 11'd1;
    y_inc      = {1'b0, pix_v_reg} + 11'd1;
    row_end    = (x_inc == xe_reg);
    last_pixel = row_end && (y_inc == ye_reg);

    unique case (state_reg)
      IDLE: begin
        if (bus.CMD_VALID) begin
          if (cmd_empty) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else begin
            state_next  = FILL;
            x0_next     = bus.CMD_X0;
            xe_next     = x_clip;
            ye_next     = y_clip;
            pix_h_next  = bus.CMD_X0;
            pix_v_next  = bus.CMD_Y0;
            pix_c_next  = bus.CMD_COLOR;
            pix_we_next = 1'b1;
          end
        end
      end
      FILL: begin
        if (last_pixel) begin
          state_next = FIN;
          done_next  = 1'b1;
        end else begin
          pix_we_next = 1'b1;
          if (row_end) begin
            pix_h_next = x0_reg;
            pix_v_next = y_inc[9:0];
          end else begin
            pix_h_next = x_inc[9:0];
          end
        end
      end
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.CMD_READY      = (state_reg == IDLE);
  assign bus.BUSY           = (state_reg != IDLE);
  assign bus.DONE           = done_reg;
  assign bus.PIX_WE         = pix_we_reg;
  assign bus.PIX_HORIZONTAL = pix_h_reg;
  assign bus.PIX_VERTICAL   = pix_v_reg;
  assign bus.PIX_COLOR      = pix_c_reg;
endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: vector table of fill commands plus
// back-to-back, reset-abort and full-screen (reduced-size instance) sequences.
module tb_rect_fill_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  rect_fill_engine_if bus ();
  rect_fill_engine_if bus2 ();

  rect_fill_engine dut (.PIXEL_CLK(clk), .RST_N(rst_n), .bus(bus));
  rect_fill_engine #(.HSIZE(40), .VSIZE(30)) dut2 (.PIXEL_CLK(clk), .RST_N(rst_n), .bus(bus2));

  typedef struct {
    int x0, y0, w, h, color;
    int cnt, xe, ye, lx, ly;   // expected pixel count, clipped end, last pixel
  } vec_t;

  typedef struct {
    int we, done, ready, x, c;
  } b2b_t;

  vec_t vecs[10];
  b2b_t b2b[10];

  int n_checks = 0;
  int n_fail = 0;
  int total_wr = 0;
  int bad_addr = 0;
  int done_total = 0;
  logic [7:0] fb [600][800];
  logic [7:0] fb2 [30][40];

  // Framebuffer model for the full-size instance.
  always @(negedge clk) begin
    if (bus.PIX_WE) begin
      total_wr++;
      if (bus.PIX_HORIZONTAL < 800 && bus.PIX_VERTICAL < 600)
        fb[bus.PIX_VERTICAL][bus.PIX_HORIZONTAL] = bus.PIX_COLOR;
      else
        bad_addr++;
    end
    if (bus.DONE) done_total++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int wr = 0, order_err = 0, done_cyc = -1, last_we = 0;
    int ex, ey, lx = -1, ly = -1, ready_bad = 0, ready_after = 0;
    @(negedge clk);
    check({tag, "_ready_in"}, bus.CMD_READY, 1);
    bus.CMD_X0 = 10'(v.x0); bus.CMD_Y0 = 10'(v.y0);
    bus.CMD_W = 10'(v.w); bus.CMD_H = 10'(v.h);
    bus.CMD_COLOR = 8'(v.color); bus.CMD_VALID = 1'b1;
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    ex = v.x0; ey = v.y0;
    for (int k = 1; k <= v.cnt + 8; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.PIX_WE) begin
        wr++; last_we = k;
        lx = bus.PIX_HORIZONTAL; ly = bus.PIX_VERTICAL;
        if (bus.PIX_HORIZONTAL != ex || bus.PIX_VERTICAL != ey || bus.PIX_COLOR != v.color)
          order_err++;
        ex++;
        if (ex == v.xe) begin ex = v.x0; ey++; end
      end
      if (bus.CMD_READY) ready_bad++;
      if (bus.DONE) begin
        done_cyc = k;
        @(negedge clk);
        ready_after = bus.CMD_READY;
        break;
      end
    end
    check({tag, "_count"}, wr, v.cnt);
    check({tag, "_last_we_cycle"}, last_we, v.cnt);
    check({tag, "_order"}, order_err, 0);
    check({tag, "_done_cycle"}, done_cyc, v.cnt + 1);
    check({tag, "_ready_low"}, ready_bad, 0);
    check({tag, "_ready_after"}, ready_after, 1);
    if (v.cnt > 0) check({tag, "_last_xy"}, lx * 1024 + ly, v.lx * 1024 + v.ly);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, done_before, act, exp, wr2, last2, done2, lx2, ly2, bad2, mism2;
    vec_t v1;

    for (int y = 0; y < 600; y++) for (int x = 0; x < 800; x++) fb[y][x] = 8'h00;
    for (int y = 0; y < 30; y++) for (int x = 0; x < 40; x++) fb2[y][x] = 8'h00;

    vecs[0] = '{10, 20, 2, 2, 'h5A, 4, 12, 22, 11, 21};
    vecs[1] = '{798, 598, 4, 4, 'hFF, 4, 800, 600, 799, 599};
    vecs[2] = '{5, 5, 0, 3, 'h33, 0, 0, 0, 0, 0};
    vecs[3] = '{5, 5, 3, 0, 'h33, 0, 0, 0, 0, 0};
    vecs[4] = '{800, 5, 2, 2, 'h33, 0, 0, 0, 0, 0};
    vecs[5] = '{5, 600, 2, 2, 'h33, 0, 0, 0, 0, 0};
    vecs[6] = '{100, 200, 3, 3, 'hA5, 9, 103, 203, 102, 202};
    vecs[7] = '{795, 10, 10, 2, 'h42, 10, 800, 12, 799, 11};
    vecs[8] = '{0, 590, 1023, 1023, 'h77, 8000, 800, 600, 799, 599};
    vecs[9] = '{0, 0, 1, 1, 'h01, 1, 1, 1, 0, 0};

    b2b[0] = '{1, 0, 0, 50, 'h0A}; b2b[1] = '{1, 0, 0, 51, 'h0A};
    b2b[2] = '{1, 0, 0, 52, 'h0A}; b2b[3] = '{0, 1, 0, 52, 'h0A};
    b2b[4] = '{0, 0, 1, 52, 'h0A}; b2b[5] = '{1, 0, 0, 53, 'h0B};
    b2b[6] = '{1, 0, 0, 54, 'h0B}; b2b[7] = '{1, 0, 0, 55, 'h0B};
    b2b[8] = '{0, 1, 0, 55, 'h0B}; b2b[9] = '{0, 0, 1, 55, 'h0B};

    bus.CMD_VALID = 1'b0; bus.CMD_X0 = '0; bus.CMD_Y0 = '0;
    bus.CMD_W = '0; bus.CMD_H = '0; bus.CMD_COLOR = '0;
    bus2.CMD_VALID = 1'b0; bus2.CMD_X0 = '0; bus2.CMD_Y0 = '0;
    bus2.CMD_W = '0; bus2.CMD_H = '0; bus2.CMD_COLOR = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", bus.CMD_READY, 1);
    check("rst_busy", bus.BUSY, 0);
    check("rst_done", bus.DONE, 0);
    check("rst_we", bus.PIX_WE, 0);
    check("rst_pix", {bus.PIX_HORIZONTAL, bus.PIX_VERTICAL, bus.PIX_COLOR}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      $display("vec %0d: (%0d,%0d) %0dx%0d color %02h, expected %0d writes", i,
               vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, vecs[i].cnt);
    end

    // Back-to-back 3x1 commands with CMD_VALID held high
    @(negedge clk);
    bus.CMD_X0 = 10'd50; bus.CMD_Y0 = 10'd60; bus.CMD_W = 10'd3; bus.CMD_H = 10'd1;
    bus.CMD_COLOR = 8'h0A; bus.CMD_VALID = 1'b1;
    @(negedge clk);
    bus.CMD_X0 = 10'd53; bus.CMD_COLOR = 8'h0B;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      act = (int'(bus.PIX_WE) << 20) | (int'(bus.DONE) << 19) | (int'(bus.CMD_READY) << 18) |
            (int'(bus.PIX_HORIZONTAL) << 8) | int'(bus.PIX_COLOR);
      exp = (b2b[k].we << 20) | (b2b[k].done << 19) | (b2b[k].ready << 18) |
            (b2b[k].x << 8) | b2b[k].c;
      check($sformatf("b2b_cycle%0d", k + 1), act, exp);
      $display("b2b cycle %0d: we=%0d done=%0d ready=%0d x=%0d", k + 1,
               bus.PIX_WE, bus.DONE, bus.CMD_READY, bus.PIX_HORIZONTAL);
      if (k == 5) bus.CMD_VALID = 1'b0;
    end

    // Reset during a 100x100 fill after 37 writes
    base = total_wr;
    @(negedge clk);
    bus.CMD_X0 = 10'd200; bus.CMD_Y0 = 10'd300; bus.CMD_W = 10'd100; bus.CMD_H = 10'd100;
    bus.CMD_COLOR = 8'h3C; bus.CMD_VALID = 1'b1;
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    repeat (36) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    done_before = done_total;
    check("abort_we", bus.PIX_WE, 0);
    check("abort_busy", bus.BUSY, 0);
    check("abort_ready", bus.CMD_READY, 1);
    check("abort_pix", {bus.PIX_HORIZONTAL, bus.PIX_VERTICAL, bus.PIX_COLOR}, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_total - done_before, 0);
    check("abort_writes", total_wr - base, 37);
    $display("reset abort: %0d pixels written before reset", total_wr - base);
    rst_n = 1'b1;
    v1 = '{5, 7, 1, 1, 'hC3, 1, 6, 8, 5, 7};
    run_vec(v1, "post_reset");

    // Framebuffer readback
    check("fb_10_20", fb[20][10], 'h5A);
    check("fb_11_21", fb[21][11], 'h5A);
    check("fb_12_20", fb[20][12], 'h00);
    check("fb_102_202", fb[202][102], 'hA5);
    check("fb_799_11", fb[11][799], 'h42);
    check("fb_799_599", fb[599][799], 'h77);
    check("fb_236_300", fb[300][236], 'h3C);
    check("fb_237_300", fb[300][237], 'h00);
    check("fb_5_7", fb[7][5], 'hC3);
    check("bad_addr", bad_addr, 0);
    check("done_total", done_total, 13);

    // Full-screen fill on the 40x30 instance
    wr2 = 0; last2 = 0; done2 = -1; lx2 = -1; ly2 = -1; bad2 = 0; mism2 = 0;
    @(negedge clk);
    bus2.CMD_X0 = 10'd0; bus2.CMD_Y0 = 10'd0; bus2.CMD_W = 10'd40; bus2.CMD_H = 10'd30;
    bus2.CMD_COLOR = 8'h11; bus2.CMD_VALID = 1'b1;
    @(negedge clk);
    bus2.CMD_VALID = 1'b0;
    for (int k = 1; k <= 1300; k++) begin
      if (k > 1) @(negedge clk);
      if (bus2.PIX_WE) begin
        wr2++; last2 = k; lx2 = bus2.PIX_HORIZONTAL; ly2 = bus2.PIX_VERTICAL;
        if (bus2.PIX_HORIZONTAL < 40 && bus2.PIX_VERTICAL < 30)
          fb2[bus2.PIX_VERTICAL][bus2.PIX_HORIZONTAL] = bus2.PIX_COLOR;
        else
          bad2++;
      end
      if (bus2.DONE) begin done2 = k; break; end
    end
    for (int y = 0; y < 30; y++) for (int x = 0; x < 40; x++) if (fb2[y][x] != 8'h11) mism2++;
    check("full_count", wr2, 1200);
    check("full_last_we_cycle", last2, 1200);
    check("full_last_xy", lx2 * 1024 + ly2, 39 * 1024 + 29);
    check("full_done_cycle", done2, 1201);
    check("full_bad_addr", bad2, 0);
    check("full_fb_wrong", mism2, 0);
    $display("full screen: %0d writes, last (%0d,%0d), done cycle %0d", wr2, lx2, ly2, done2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
